// File: rtl/ex_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_stage_if : ID/EX operand bus and EX/MEM result bus for ex_stage |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ex_stage_if #(
  parameter int CODE_W = 4,
  parameter int WORD_W = 32,
  parameter int PC_W   = 32
);
  logic [CODE_W-1:0] ex_icode;
  logic [CODE_W-1:0] ex_ifun;
  logic [WORD_W-1:0] ex_valA;
  logic [WORD_W-1:0] ex_valB;
  logic [WORD_W-1:0] ex_valC;
  logic [PC_W-1:0]   ex_valP;
  logic              cc_en;
  logic              stall;
  logic              bubble;
  logic [CODE_W-1:0] mem_icode;
  logic              mem_cnd;
  logic [WORD_W-1:0] mem_valE;
  logic [WORD_W-1:0] mem_valA;
  logic [PC_W-1:0]   mem_valP;
  logic [2:0]        cc;

  modport master (
    output ex_icode, ex_ifun, ex_valA, ex_valB, ex_valC, ex_valP,
    output cc_en, stall, bubble,
    input  mem_icode, mem_cnd, mem_valE, mem_valA, mem_valP, cc
  );

  modport slave (
    input  ex_icode, ex_ifun, ex_valA, ex_valB, ex_valC, ex_valP,
    input  cc_en, stall, bubble,
    output mem_icode, mem_cnd, mem_valE, mem_valA, mem_valP, cc
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_stage : Y86 execute stage - ALU, condition codes, Cnd, EX/MEM  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module ex_stage #(
  parameter int CODE_W = 4,
  parameter int WORD_W = 32,
  parameter int PC_W   = 32
) (
  input  wire         clk,
  input  wire         rst,
  ex_stage_if.slave   bus
);

  localparam logic [CODE_W-1:0] c_INOP    = CODE_W'(1);
  localparam logic [CODE_W-1:0] c_IRRMOV  = CODE_W'(2);
  localparam logic [CODE_W-1:0] c_IIRMOV  = CODE_W'(3);
  localparam logic [CODE_W-1:0] c_IRMMOV  = CODE_W'(4);
  localparam logic [CODE_W-1:0] c_IMRMOV  = CODE_W'(5);
  localparam logic [CODE_W-1:0] c_IOPL    = CODE_W'(6);
  localparam logic [CODE_W-1:0] c_IJXX    = CODE_W'(7);
  localparam logic [CODE_W-1:0] c_ICALL   = CODE_W'(8);
  localparam logic [CODE_W-1:0] c_IRET    = CODE_W'(9);
  localparam logic [CODE_W-1:0] c_IPUSH   = CODE_W'(10);
  localparam logic [CODE_W-1:0] c_IPOP    = CODE_W'(11);
  localparam logic [WORD_W-1:0] c_STACK_STEP = WORD_W'(4);
  localparam int                c_MSB     = WORD_W - 1;

  logic [CODE_W-1:0] mem_icode_q, mem_icode_d;
  logic              mem_cnd_q,   mem_cnd_d;
  logic [WORD_W-1:0] mem_valE_q,  mem_valE_d;
  logic [WORD_W-1:0] mem_valA_q;
  logic [PC_W-1:0]   mem_valP_q;
  logic [2:0]        cc_q,        cc_d;
  logic              opl_valid;
  logic              cc_we;
  logic              zf, sf, of;

  assign opl_valid = (bus.ex_icode == c_IOPL) && (bus.ex_ifun <= CODE_W'(3));
  assign cc_we     = opl_valid && bus.cc_en && !bus.stall && !bus.bubble;
  assign {zf, sf, of} = cc_q;

  always_comb begin
    mem_valE_d = '0;
    case (bus.ex_icode)
      c_IRRMOV:           mem_valE_d = bus.ex_valA;
      c_IIRMOV:           mem_valE_d = bus.ex_valC;
      c_IRMMOV, c_IMRMOV: mem_valE_d = bus.ex_valB + bus.ex_valC;
      c_IOPL: begin
        case (bus.ex_ifun)
          CODE_W'(0): mem_valE_d = bus.ex_valB + bus.ex_valA;
          CODE_W'(1): mem_valE_d = bus.ex_valB - bus.ex_valA;
          CODE_W'(2): mem_valE_d = bus.ex_valB & bus.ex_valA;
          CODE_W'(3): mem_valE_d = bus.ex_valB ^ bus.ex_valA;
          default:    mem_valE_d = '0;
        endcase
      end
      c_ICALL, c_IPUSH:   mem_valE_d = bus.ex_valB - c_STACK_STEP;
      c_IRET, c_IPOP:     mem_valE_d = bus.ex_valB + c_STACK_STEP;
      default:            mem_valE_d = '0;
    endcase
  end

  // Overflow: add overflows when like-signed operands give an unlike-signed sum;
  // B-A overflows when operands differ in sign and the result sign leaves B's.
  always_comb begin
    cc_d    = cc_q;
    cc_d[2] = (mem_valE_d == '0);
    cc_d[1] = mem_valE_d[c_MSB];
    cc_d[0] = 1'b0;
    if (bus.ex_ifun == CODE_W'(0)) begin
      cc_d[0] = (bus.ex_valA[c_MSB] == bus.ex_valB[c_MSB]) &&
                (mem_valE_d[c_MSB] != bus.ex_valA[c_MSB]);
    end else if (bus.ex_ifun == CODE_W'(1)) begin
      cc_d[0] = (bus.ex_valA[c_MSB] != bus.ex_valB[c_MSB]) &&
                (mem_valE_d[c_MSB] != bus.ex_valB[c_MSB]);
    end
  end

  always_comb begin
    mem_cnd_d = 1'b0;
    if ((bus.ex_icode == c_IRRMOV) || (bus.ex_icode == c_IJXX)) begin
      case (bus.ex_ifun)
        CODE_W'(0): mem_cnd_d = 1'b1;
        CODE_W'(1): mem_cnd_d = (sf ^ of) | zf;
        CODE_W'(2): mem_cnd_d = sf ^ of;
        CODE_W'(3): mem_cnd_d = zf;
        CODE_W'(4): mem_cnd_d = ~zf;
        CODE_W'(5): mem_cnd_d = ~(sf ^ of);
        CODE_W'(6): mem_cnd_d = ~(sf ^ of) & ~zf;
        default:    mem_cnd_d = 1'b0;
      endcase
    end
  end

  assign mem_icode_d = bus.ex_icode;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_icode_q <= c_INOP;
      mem_cnd_q   <= 1'b0;
      mem_valE_q  <= '0;
      mem_valA_q  <= '0;
      mem_valP_q  <= '0;
      cc_q        <= 3'b100;
    end else if (!bus.stall) begin
      if (bus.bubble) begin
        mem_icode_q <= c_INOP;
        mem_cnd_q   <= 1'b0;
        mem_valE_q  <= '0;
        mem_valA_q  <= '0;
        mem_valP_q  <= '0;
      end else begin
        mem_icode_q <= mem_icode_d;
        mem_cnd_q   <= mem_cnd_d;
        mem_valE_q  <= mem_valE_d;
        mem_valA_q  <= bus.ex_valA;
        mem_valP_q  <= bus.ex_valP;
      end
      if (cc_we) begin
        cc_q <= cc_d;
      end
    end
  end

  assign bus.mem_icode = mem_icode_q;
  assign bus.mem_cnd   = mem_cnd_q;
  assign bus.mem_valE  = mem_valE_q;
  assign bus.mem_valA  = mem_valA_q;
  assign bus.mem_valP  = mem_valP_q;
  assign bus.cc        = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ex_stage : directed-vector scoreboard bench for ex_stage       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ex_stage;

  logic clk;
  logic rst;

  ex_stage_if #(.CODE_W(4), .WORD_W(32), .PC_W(32)) bus ();

  ex_stage #(.CODE_W(4), .WORD_W(32), .PC_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  icode;
    logic        cnd;
    logic [31:0] valE;
    logic [31:0] valA;
    logic [31:0] valP;
    logic [2:0]  cc;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, exp);
    end
  endtask

  // Issue one cycle of inputs and queue the EX/MEM state expected after the next edge.
  task automatic step(input string nm, input logic r, input logic st, input logic bu, input logic ce,
                      input logic [3:0] ic, input logic [3:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] p,
                      input logic [3:0] e_ic, input logic e_cnd, input logic [31:0] e_valE, input logic [2:0] e_cc);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.stall    = st;
    bus.bubble   = bu;
    bus.cc_en    = ce;
    bus.ex_icode = ic;
    bus.ex_ifun  = fn;
    bus.ex_valA  = a;
    bus.ex_valB  = b;
    bus.ex_valC  = c;
    bus.ex_valP  = p;
    e.name  = nm;
    e.icode = e_ic;
    e.cnd   = e_cnd;
    e.valE  = e_valE;
    e.cc    = e_cc;
    if (!r)      begin e.valA = 32'h0;     e.valP = 32'h0;     end
    else if (st) begin e.valA = prev.valA; e.valP = prev.valP; end
    else if (bu) begin e.valA = 32'h0;     e.valP = 32'h0;     end
    else         begin e.valA = a;         e.valP = p;         end
    prev = e;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "icode", 32'(bus.mem_icode), 32'(e.icode));
        chk(e.name, "cnd",   32'(bus.mem_cnd),   32'(e.cnd));
        chk(e.name, "valE",  bus.mem_valE,       e.valE);
        chk(e.name, "valA",  bus.mem_valA,       e.valA);
        chk(e.name, "valP",  bus.mem_valP,       e.valP);
        chk(e.name, "cc",    32'(bus.cc),        32'(e.cc));
      end
    end
  end

  initial begin : driver
    int waited;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; bus.stall = 1'b0; bus.bubble = 1'b0; bus.cc_en = 1'b1;
    bus.ex_icode = 4'h1; bus.ex_ifun = 4'h0;
    bus.ex_valA = '0; bus.ex_valB = '0; bus.ex_valC = '0; bus.ex_valP = '0;
    repeat (2) @(posedge clk);

    //    name        rst st bu ce  ic    fn    valA          valB          valC      valP      e_ic  cnd  e_valE        e_cc
    step("reset",     0, 0, 0, 1, 4'h6, 4'h0, 32'h1,        32'h1,        32'h0,    32'h4,    4'h1, 0, 32'h0,        3'b100);
    step("addl_ovf",  1, 0, 0, 1, 4'h6, 4'h0, 32'h7FFFFFFF, 32'h1,        32'h0,    32'h10,   4'h6, 0, 32'h80000000, 3'b011);
    step("subl_zero", 1, 0, 0, 1, 4'h6, 4'h1, 32'h5,        32'h5,        32'h0,    32'h12,   4'h6, 0, 32'h0,        3'b100);
    step("subl_neg",  1, 0, 0, 1, 4'h6, 4'h1, 32'h5,        32'h3,        32'h0,    32'h14,   4'h6, 0, 32'hFFFFFFFE, 3'b010);
    step("cmovl",     1, 0, 0, 1, 4'h2, 4'h2, 32'h55,       32'h0,        32'h0,    32'h16,   4'h2, 1, 32'h55,       3'b010);
    step("jl",        1, 0, 0, 1, 4'h7, 4'h2, 32'h0,        32'h0,        32'h200,  32'h1B,   4'h7, 1, 32'h0,        3'b010);
    step("jg",        1, 0, 0, 1, 4'h7, 4'h6, 32'h0,        32'h0,        32'h200,  32'h20,   4'h7, 0, 32'h0,        3'b010);
    step("je",        1, 0, 0, 1, 4'h7, 4'h3, 32'h0,        32'h0,        32'h200,  32'h25,   4'h7, 0, 32'h0,        3'b010);
    step("jne",       1, 0, 0, 1, 4'h7, 4'h4, 32'h0,        32'h0,        32'h200,  32'h2A,   4'h7, 1, 32'h0,        3'b010);
    step("jle",       1, 0, 0, 1, 4'h7, 4'h1, 32'h0,        32'h0,        32'h200,  32'h2F,   4'h7, 1, 32'h0,        3'b010);
    step("jmp",       1, 0, 0, 1, 4'h7, 4'h0, 32'h0,        32'h0,        32'h200,  32'h34,   4'h7, 1, 32'h0,        3'b010);
    step("j_bad",     1, 0, 0, 1, 4'h7, 4'h7, 32'h0,        32'h0,        32'h200,  32'h39,   4'h7, 0, 32'h0,        3'b010);
    step("push",      1, 0, 0, 1, 4'hA, 4'h0, 32'hABCD,     32'h100,      32'h0,    32'h3E,   4'hA, 0, 32'hFC,       3'b010);
    step("pop",       1, 0, 0, 1, 4'hB, 4'h0, 32'h0,        32'hFC,       32'h0,    32'h40,   4'hB, 0, 32'h100,      3'b010);
    step("call",      1, 0, 0, 1, 4'h8, 4'h0, 32'h0,        32'h80,       32'h300,  32'h42,   4'h8, 0, 32'h7C,       3'b010);
    step("ret",       1, 0, 0, 1, 4'h9, 4'h0, 32'h0,        32'h7C,       32'h0,    32'h47,   4'h9, 0, 32'h80,       3'b010);
    step("rmmov",     1, 0, 0, 1, 4'h4, 4'h0, 32'h9,        32'h10,       32'h8,    32'h48,   4'h4, 0, 32'h18,       3'b010);
    step("mrmov",     1, 0, 0, 1, 4'h5, 4'h0, 32'h0,        32'h20,       32'h4,    32'h4E,   4'h5, 0, 32'h24,       3'b010);
    step("irmov",     1, 0, 0, 1, 4'h3, 4'h0, 32'h0,        32'h0,        32'h1234, 32'h54,   4'h3, 0, 32'h1234,     3'b010);
    step("halt_zero", 1, 0, 0, 1, 4'h0, 4'h0, 32'h7,        32'h7,        32'h7,    32'h5A,   4'h0, 0, 32'h0,        3'b010);
    step("andl",      1, 0, 0, 1, 4'h6, 4'h2, 32'hF0F0,     32'h0FF0,     32'h0,    32'h5B,   4'h6, 0, 32'h00F0,     3'b000);
    step("xorl_zero", 1, 0, 0, 1, 4'h6, 4'h3, 32'hAAAA,     32'hAAAA,     32'h0,    32'h5D,   4'h6, 0, 32'h0,        3'b100);
    step("subl_ovf",  1, 0, 0, 1, 4'h6, 4'h1, 32'h1,        32'h80000000, 32'h0,    32'h5F,   4'h6, 0, 32'h7FFFFFFF, 3'b001);
    step("jl_of",     1, 0, 0, 1, 4'h7, 4'h2, 32'h0,        32'h0,        32'h0,    32'h61,   4'h7, 1, 32'h0,        3'b001);
    step("jge_of",    1, 0, 0, 1, 4'h7, 4'h5, 32'h0,        32'h0,        32'h0,    32'h66,   4'h7, 0, 32'h0,        3'b001);
    step("opl_bad",   1, 0, 0, 1, 4'h6, 4'h4, 32'h3,        32'h3,        32'h0,    32'h6B,   4'h6, 0, 32'h0,        3'b001);
    step("stall_bub", 1, 1, 1, 1, 4'h6, 4'h0, 32'h1,        32'h1,        32'h0,    32'h70,   4'h6, 0, 32'h0,        3'b001);
    step("stall",     1, 1, 0, 1, 4'h6, 4'h0, 32'h1,        32'h1,        32'h0,    32'h72,   4'h6, 0, 32'h0,        3'b001);
    step("bubble",    1, 0, 1, 1, 4'h6, 4'h0, 32'h1,        32'h1,        32'h0,    32'h74,   4'h1, 0, 32'h0,        3'b001);
    step("cc_en_off", 1, 0, 0, 0, 4'h6, 4'h0, 32'h1,        32'h2,        32'h0,    32'h76,   4'h6, 0, 32'h3,        3'b001);
    step("rst_stall", 0, 1, 1, 1, 4'h6, 4'h0, 32'h1,        32'h2,        32'h0,    32'h78,   4'h1, 0, 32'h0,        3'b100);
    step("addl_post", 1, 0, 0, 1, 4'h6, 4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,    32'h7A,   4'h6, 0, 32'h0,        3'b100);

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
